// File: rtl/risc_pkg.sv
// Shared pipeline definitions: register-file geometry, counter width,
// hazard-controller state encodings and a saturating increment helper.
package risc_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int CNT_W      = 16;

    // Register 0 is hard-wired to zero, so writes to it never create a hazard.
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/hazard_cmp.sv
// One forwarding-less hazard detector: does an in-flight writer target a
// register the DOF instruction is about to read?
module hazard_cmp
    import risc_pkg::*;
(
    input  logic                  rw,
    input  logic [REG_ADDR_W-1:0] da,
    input  logic [REG_ADDR_W-1:0] aa,
    input  logic [REG_ADDR_W-1:0] ba,
    input  logic                  a_used,
    input  logic                  b_used,
    output logic                  hit
);

    logic match_a;
    logic match_b;

    assign match_a = a_used & (da == aa);
    assign match_b = b_used & (da == ba);
    assign hit     = rw & (da != REG_ZERO) & (match_a | match_b);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stalls IF/DOF on RAW hazards against EX/WB,
// flushes on taken branches, and counts stall cycles and accepted flushes.
module hazard_ctrl
    import risc_pkg::*;
(
    input  logic                  clock,
    input  logic                  reset,
    input  logic [REG_ADDR_W-1:0] aa_dof,
    input  logic [REG_ADDR_W-1:0] ba_dof,
    input  logic                  a_used,
    input  logic                  b_used,
    input  logic                  rw_ex,
    input  logic [REG_ADDR_W-1:0] da_ex,
    input  logic                  rw_wb,
    input  logic [REG_ADDR_W-1:0] da_wb,
    input  logic                  br_taken,
    output logic                  pc_en,
    output logic                  dof_en,
    output logic                  dof_bubble,
    output logic                  if_flush,
    output logic [1:0]            state,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    state_t state_q;
    state_t state_d;
    logic   hazard_ex;
    logic   hazard_wb;
    logic   hazard;
    logic   stall_ev;
    logic   flush_ev;

    hazard_cmp u_cmp_ex (
        .rw     (rw_ex),
        .da     (da_ex),
        .aa     (aa_dof),
        .ba     (ba_dof),
        .a_used (a_used),
        .b_used (b_used),
        .hit    (hazard_ex)
    );

    hazard_cmp u_cmp_wb (
        .rw     (rw_wb),
        .da     (da_wb),
        .aa     (aa_dof),
        .ba     (ba_dof),
        .a_used (a_used),
        .b_used (b_used),
        .hit    (hazard_wb)
    );

    assign hazard = hazard_ex | hazard_wb;
    assign state  = state_q;

    // Next-state and output decode; branch beats hazard, FLUSH always returns to RUN.
    always_comb begin
        pc_en      = 1'b1;
        dof_en     = 1'b1;
        dof_bubble = 1'b0;
        if_flush   = 1'b0;
        stall_ev   = 1'b0;
        flush_ev   = 1'b0;
        state_d    = ST_RUN;
        case (state_q)
            ST_RUN, ST_STALL: begin
                if (br_taken) begin
                    dof_bubble = 1'b1;
                    if_flush   = 1'b1;
                    flush_ev   = 1'b1;
                    state_d    = ST_FLUSH;
                end else if (hazard) begin
                    pc_en      = 1'b0;
                    dof_en     = 1'b0;
                    dof_bubble = 1'b1;
                    stall_ev   = 1'b1;
                    state_d    = ST_STALL;
                end
            end
            // FLUSH and the unused encoding both run freely and head back to RUN.
            default: state_d = ST_RUN;
        endcase
        // Reset holds the front end frozen with NOPs in flight, whatever the inputs.
        if (!reset) begin
            pc_en      = 1'b0;
            dof_en     = 1'b0;
            dof_bubble = 1'b1;
            if_flush   = 1'b1;
            stall_ev   = 1'b0;
            flush_ev   = 1'b0;
        end
    end

    // State register and saturating event counters.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_RUN;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (stall_ev) stall_cnt <= sat_inc(stall_cnt);
            if (flush_ev) flush_cnt <= sat_inc(flush_cnt);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// traffic, all checked against a behavioural model of the controller rules.
module tb_hazard_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  aa_dof, ba_dof, da_ex, da_wb;
    logic        a_used, b_used, rw_ex, rw_wb, br_taken;
    logic        pc_en, dof_en, dof_bubble, if_flush;
    logic [1:0]  state;
    logic [15:0] stall_cnt, flush_cnt;

    int total = 0;
    int bad   = 0;

    // Model: 0 = RUN, 1 = STALL, 2 = FLUSH
    int m_state = 0;
    int m_stall = 0;
    int m_flush = 0;

    hazard_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .aa_dof     (aa_dof),
        .ba_dof     (ba_dof),
        .a_used     (a_used),
        .b_used     (b_used),
        .rw_ex      (rw_ex),
        .da_ex      (da_ex),
        .rw_wb      (rw_wb),
        .da_wb      (da_wb),
        .br_taken   (br_taken),
        .pc_en      (pc_en),
        .dof_en     (dof_en),
        .dof_bubble (dof_bubble),
        .if_flush   (if_flush),
        .state      (state),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    always #5 clock = ~clock;

    function automatic bit model_hazard();
        bit h = 0;
        if (rw_ex && da_ex != 0 && ((a_used && da_ex == aa_dof) || (b_used && da_ex == ba_dof))) h = 1;
        if (rw_wb && da_wb != 0 && ((a_used && da_wb == aa_dof) || (b_used && da_wb == ba_dof))) h = 1;
        return h;
    endfunction

    // Expected {pc_en, dof_en, dof_bubble, if_flush}
    function automatic logic [3:0] model_out();
        if (!reset)          return 4'b0011;
        if (m_state == 2)    return 4'b1100;
        if (br_taken)        return 4'b1111;
        if (model_hazard())  return 4'b0010;
        return 4'b1100;
    endfunction

    task automatic set_in(input bit rwe, input int dae, input bit rww, input int daw,
                          input int aa, input int ba, input bit au, input bit bu, input bit br);
        rw_ex = rwe; da_ex = 5'(dae); rw_wb = rww; da_wb = 5'(daw);
        aa_dof = 5'(aa); ba_dof = 5'(ba); a_used = au; b_used = bu; br_taken = br;
        #1;
    endtask

    // Advance one clock and move the model along with it.
    task automatic tick();
        int ns = 0, st = m_stall, fl = m_flush;
        if (m_state != 2 && br_taken) begin
            ns = 2; fl = (m_flush < 65535) ? m_flush + 1 : 65535;
        end else if (m_state != 2 && model_hazard()) begin
            ns = 1; st = (m_stall < 65535) ? m_stall + 1 : 65535;
        end
        @(posedge clock);
        #1;
        m_state = ns; m_stall = st; m_flush = fl;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #3;
        m_state = 0; m_stall = 0; m_flush = 0;
        @(negedge clock);
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(1'($urandom), $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom), 1'($urandom));
            total++; if ({pc_en, dof_en, dof_bubble, if_flush} !== 4'b0011) begin bad++; $display("FAIL reset_outs got=%b want=0011", {pc_en, dof_en, dof_bubble, if_flush}); end
            total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
            total++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d/%0d want=0/0", stall_cnt, flush_cnt); end
            #7;
        end
        do_reset();
    endtask

    task automatic test_stall_ex();
        do_reset();
        set_in(1, 3, 0, 0, 3, 0, 1, 0, 0);
        total++; if (pc_en !== 1'b0 || dof_bubble !== 1'b1) begin bad++; $display("FAIL stall_ex_outs got pc_en=%b bubble=%b want 0/1", pc_en, dof_bubble); end
        tick();
        total++; if (state !== 2'd1) begin bad++; $display("FAIL stall_ex_state got=%0d want=1", state); end
        set_in(0, 3, 0, 0, 3, 0, 1, 0, 0);
        total++; if (pc_en !== 1'b1 || dof_bubble !== 1'b0) begin bad++; $display("FAIL stall_release_outs got pc_en=%b bubble=%b want 1/0", pc_en, dof_bubble); end
        tick();
        total++; if (state !== 2'd0 || stall_cnt !== 16'd1) begin bad++; $display("FAIL stall_release got state=%0d cnt=%0d want 0/1", state, stall_cnt); end
    endtask

    task automatic test_reg_zero();
        set_in(0, 0, 1, 0, 0, 0, 1, 0, 0);
        total++; if (pc_en !== 1'b1 || dof_bubble !== 1'b0) begin bad++; $display("FAIL reg_zero_outs got pc_en=%b bubble=%b want 1/0", pc_en, dof_bubble); end
        tick();
        total++; if (state !== 2'd0 || stall_cnt !== 16'd1) begin bad++; $display("FAIL reg_zero got state=%0d cnt=%0d want 0/1", state, stall_cnt); end
    endtask

    task automatic test_branch_priority();
        set_in(1, 7, 0, 0, 7, 0, 1, 0, 1);
        total++; if ({pc_en, dof_bubble, if_flush} !== 3'b111) begin bad++; $display("FAIL br_prio_outs got=%b want=111", {pc_en, dof_bubble, if_flush}); end
        tick();
        total++; if (state !== 2'd2 || flush_cnt !== 16'd1 || stall_cnt !== 16'd1) begin bad++; $display("FAIL br_prio got state=%0d fl=%0d st=%0d want 2/1/1", state, flush_cnt, stall_cnt); end
    endtask

    task automatic test_branch_hold();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
        total++; if (if_flush !== 1'b1) begin bad++; $display("FAIL br_hold_c1 got if_flush=%b want 1", if_flush); end
        tick();
        total++; if ({pc_en, dof_en, dof_bubble, if_flush} !== 4'b1100 || state !== 2'd2) begin bad++; $display("FAIL br_hold_c2 got outs=%b state=%0d want 1100/2", {pc_en, dof_en, dof_bubble, if_flush}, state); end
        tick();
        total++; if (state !== 2'd0 || flush_cnt !== 16'd2) begin bad++; $display("FAIL br_hold_end got state=%0d fl=%0d want 0/2", state, flush_cnt); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_in(1'($urandom), $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
                   ($urandom_range(0, 5) == 0));
            total++; if ({pc_en, dof_en, dof_bubble, if_flush} !== model_out()) begin bad++; $display("FAIL rand_outs cyc=%0d got=%b want=%b", i, {pc_en, dof_en, dof_bubble, if_flush}, model_out()); end
            total++; if (if_flush && !pc_en) begin bad++; $display("FAIL rand_flush_pc cyc=%0d if_flush=%b pc_en=%b", i, if_flush, pc_en); end
            tick();
            total++; if (int'(state) != m_state || int'(stall_cnt) != m_stall || int'(flush_cnt) != m_flush) begin bad++; $display("FAIL rand_state cyc=%0d got %0d/%0d/%0d want %0d/%0d/%0d", i, state, stall_cnt, flush_cnt, m_state, m_stall, m_flush); end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        set_in(0, 0, 1, 9, 0, 9, 0, 1, 0);
        for (int i = 0; i < 16'hFFFE; i++) tick();
        total++; if (stall_cnt !== 16'hFFFE || int'(stall_cnt) != m_stall) begin bad++; $display("FAIL sat_preload got=%h want=fffe", stall_cnt); end
        for (int i = 0; i < 3; i++) tick();
        total++; if (stall_cnt !== 16'hFFFF || int'(stall_cnt) != m_stall) begin bad++; $display("FAIL sat_hold got=%h want=ffff", stall_cnt); end
    endtask

    task automatic test_reset_mid_stall();
        set_in(1, 4, 0, 0, 0, 4, 0, 1, 0);
        tick();
        #2;
        reset = 1'b0;
        #1;
        m_state = 0; m_stall = 0; m_flush = 0;
        total++; if (state !== 2'd0 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin bad++; $display("FAIL rst_mid_regs got %0d/%0d/%0d want 0/0/0", state, stall_cnt, flush_cnt); end
        total++; if (pc_en !== 1'b0 || if_flush !== 1'b1) begin bad++; $display("FAIL rst_mid_outs got pc_en=%b if_flush=%b want 0/1", pc_en, if_flush); end
        @(negedge clock);
        reset = 1'b1;
        #1;
        total++; if ({pc_en, dof_en, dof_bubble, if_flush} !== 4'b0010) begin bad++; $display("FAIL rst_release_outs got=%b want=0010", {pc_en, dof_en, dof_bubble, if_flush}); end
        tick();
        total++; if (state !== 2'd1 || stall_cnt !== 16'd1) begin bad++; $display("FAIL rst_release got state=%0d cnt=%0d want 1/1", state, stall_cnt); end
    endtask

    initial begin
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_stall_ex();
        test_reg_zero();
        test_branch_priority();
        test_branch_hold();
        test_random();
        test_saturation();
        test_reset_mid_stall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
